game_event_controller: RTL and testbench
========================================

Name: game_event_controller

Overview:
- Parametrised successor to the single-gold, single-alien collision controller.
- Per pixel, watches the drawing requests of the player, shot, terrain, N_ALIEN aliens and N_GOLD gold bags, and records overlaps in per-frame sticky latches.
- At startOfFrame it publishes those latches as one-cycle game events.
- Owns the player death/respawn sequence, so events are suppressed while the player is dying.

Parameters:
- N_GOLD, 4, number of gold bag channels (1..8).
- N_ALIEN, 2, number of alien channels (1..8).
- DEATH_FRAMES, 60, frames spent in the DYING state before respawn (1..255).

Ports:
- clk  in  1  pixel clock (25 MHz).
- resetN  in  1  synchronous, active-high reset.
- startOfFrame  in  1  high for one clk at pixel (0,0).
- player_awake  in  1  player is active; player collisions are ignored when low.
- player_dr  in  1  player drawing request.
- terrain_dr  in  1  terrain drawing request.
- shot_dr  in  1  shot drawing request.
- alien_dr  in  N_ALIEN  per-alien drawing request.
- gold_dr  in  N_GOLD  per-gold drawing request.
- gold_state  in  N_GOLD x 4  per-gold state, gold_state_t from the package.
- collision_player_terrain  out  1  level; the player touched terrain in the previous frame.
- colision_fire  out  1  pulse; the shot hit an alien or terrain.
- collision_gold  out  N_GOLD  pulse per gold; the player pushed a still gold bag.
- player_eat_gold  out  N_GOLD  pulse per gold; the player collected broken gold.
- alien_died  out  N_ALIEN  pulse per alien.
- player_died  out  1  pulse at entry to DYING.
- player_dying  out  1  level while the FSM is in DYING.

Behaviour:
- Reset: all outputs 0, all latches 0, FSM in ALIVE, frame counter 0.
- Overlap detection each clk (combinational on inputs, OR'd into sticky latches on the next edge):
  - pt = player_dr & terrain_dr & player_awake
  - pa = player_dr & |alien_dr & player_awake
  - sa[i] = shot_dr & alien_dr[i]
  - st = shot_dr & terrain_dr
  - pg[i] = player_dr & gold_dr[i] & player_awake
- Gold action by gold_state for an overlap pg[i]:
  - GOLD_STILL: latch push[i].
  - GOLD_BROKEN: latch eat[i].
  - GOLD_FALLING: latch kill.
  - Any other state: ignored.
- On the clk where startOfFrame=1:
  - Publish: outputs are registered from the latches and valid on the next clk for exactly one clk. collision_player_terrain is the exception: it holds its value for the whole frame.
  - Clear all latches in the same cycle. An overlap present on that same cycle is latched into the new frame.
- Shot priority:
  - If several sa[i] are latched in one frame, only the lowest index i gets alien_died[i]; the others are discarded.
  - colision_fire = |sa | st.
- Death FSM, states ALIVE, DYING, RESPAWN:
  - ALIVE -> DYING at publish if the pa or kill latch is set. player_died pulses with the other published events.
  - DYING: all player-related outputs (player_eat_gold, collision_gold, collision_player_terrain, and player_died after the first pulse) are forced to 0. alien_died and colision_fire stay live. The frame counter increments on each startOfFrame.
  - DYING -> RESPAWN when the counter reaches DEATH_FRAMES-1 at a startOfFrame.
  - RESPAWN: latches are held cleared for one full frame, then the FSM goes to ALIVE at the next startOfFrame.
- Simultaneous events: a kill and an eat in the same frame give both pulses, then entry to DYING.
- Reset asserted mid-frame clears everything immediately; the next publish reports nothing.
- Widths: the frame counter is $clog2(DEATH_FRAMES+1) bits and saturates.

Optional Feature:
- Macro GAME_EVENT_STATS_EN.
- Defined:
  - Adds outputs aliens_killed[7:0] and gold_eaten[7:0].
  - Both are saturating counters, incremented by the popcount of the published alien_died / player_eat_gold.
  - Cleared only by reset.
- Undefined: neither port nor counter exists; the rest of the block behaves identically.

Decomposition:
- game_pkg holds gold_state_t (GOLD_STILL, GOLD_WOBBLE, GOLD_FALLING, GOLD_BROKEN, GOLD_EATEN), death_state_t, and the DEATH_FRAMES default.
- One sub-module, frame_event_latch #(W): W sticky bits, a clear/publish on startOfFrame, and a one-cycle pulse output register. It is instantiated per event group.

Test Plan:
1. Reset, then player_dr & terrain_dr for 3 clk mid-frame, then startOfFrame -> collision_player_terrain=1 from startOfFrame+1 until the next publish.
2. Overlap sa[1] and sa[3] in the same frame (N_ALIEN=4) -> at publish alien_died=4'b0010 for 1 clk and colision_fire=1 for 1 clk.
3. Player over gold[2] with GOLD_BROKEN, plus player over gold[0] with GOLD_STILL -> player_eat_gold=4'b0100 and collision_gold=4'b0001 pulse once.
4. Player over falling gold[1] -> player_died pulse, then player_dying=1 for exactly DEATH_FRAMES frames. An eat overlap during DYING gives no pulse. One frame of RESPAWN, then ALIVE.
5. Overlap exactly on the startOfFrame cycle -> nothing published at that edge; published at the following startOfFrame.
6. With GAME_EVENT_STATS_EN: 300 eat events -> gold_eaten saturates at 255.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types, defaults and small arithmetic helpers for the game event controller.
package game_pkg;

    typedef enum logic [3:0] {
        GOLD_STILL   = 4'd0,
        GOLD_WOBBLE  = 4'd1,
        GOLD_FALLING = 4'd2,
        GOLD_BROKEN  = 4'd3,
        GOLD_EATEN   = 4'd4
    } gold_state_t;

    typedef enum logic [1:0] {
        ALIVE   = 2'd0,
        DYING   = 2'd1,
        RESPAWN = 2'd2
    } death_state_t;

    localparam int DEATH_FRAMES_DEFAULT = 60;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'd0, b};
        if (s[8]) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
    endfunction

endpackage

// File: rtl/game_event_controller_frame_event_latch.sv
// Sticky per-frame event bits, restarted at start of frame, with a registered publish output.
module frame_event_latch
    import game_pkg::*;
#(
    parameter int W      = 1,
    parameter int PRIO_W = 0,
    parameter bit LEVEL  = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sof,
    input  logic         hold,
    input  logic [W-1:0] set,
    input  logic [W-1:0] en,
    output logic [W-1:0] pulse
);

    logic [W-1:0] latch_r;
    logic [W-1:0] pick_s;

    // Keep only the lowest set bit among the low PRIO_W bits; higher bits pass through.
    function automatic logic [W-1:0] lowest_pick(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         seen;
        r    = v;
        seen = 1'b0;
        for (int i = 0; i < PRIO_W; i++) begin
            if (seen) begin
                r[i] = 1'b0;
            end else begin
                seen = v[i];
            end
        end
        return r;
    endfunction

    // Value to publish at the frame boundary.
    always_comb begin
        pick_s = lowest_pick(latch_r) & en;
    end

    // Accumulate overlaps; at start of frame publish and restart with this cycle's overlaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_r <= {W{1'b0}};
            pulse   <= {W{1'b0}};
        end else if (sof) begin
            latch_r <= set;
            pulse   <= pick_s;
        end else begin
            latch_r <= hold ? {W{1'b0}} : (latch_r | set);
            pulse   <= LEVEL ? pulse : {W{1'b0}};
        end
    end

endmodule

// File: rtl/game_event_controller.sv
// Per-pixel collision latching, frame-rate event publication and player death sequencing.
// Defining GAME_EVENT_STATS_EN adds saturating aliens_killed / gold_eaten statistics outputs.
module game_event_controller
    import game_pkg::*;
#(
    parameter int N_GOLD       = 4,
    parameter int N_ALIEN      = 2,
    parameter int DEATH_FRAMES = DEATH_FRAMES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic                     player_awake,
    input  logic                     player_dr,
    input  logic                     terrain_dr,
    input  logic                     shot_dr,
    input  logic [N_ALIEN-1:0]       alien_dr,
    input  logic [N_GOLD-1:0]        gold_dr,
    input  gold_state_t [N_GOLD-1:0] gold_state,
    output logic                     collision_player_terrain,
    output logic                     colision_fire,
    output logic [N_GOLD-1:0]        collision_gold,
    output logic [N_GOLD-1:0]        player_eat_gold,
    output logic [N_ALIEN-1:0]       alien_died,
`ifdef GAME_EVENT_STATS_EN
    output logic [7:0]               aliens_killed,
    output logic [7:0]               gold_eaten,
`endif
    output logic                     player_died,
    output logic                     player_dying
);

    localparam int            CW         = $clog2(DEATH_FRAMES + 1);
    localparam logic [CW-1:0] LAST_FRAME = CW'(DEATH_FRAMES - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEATH_FRAMES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    death_state_t              state_r;
    death_state_t              state_next_s;
    logic [CW-1:0]             frame_cnt_r;
    logic                      kill_lat_r;
    logic                      pt_s, pa_s, st_s, fire_s, kill_s;
    logic [N_ALIEN-1:0]        sa_s;
    logic [N_GOLD-1:0]         pg_s, push_s, eat_s;
    logic                      alive_s, respawn_s, stay_alive_s;
    logic [N_ALIEN:0]          shot_pulse_s;
    logic [2*N_GOLD-1:0]       gold_pulse_s;

    // Overlap detection for the current pixel.
    always_comb begin
        pt_s   = player_dr & terrain_dr & player_awake;
        pa_s   = player_dr & (|alien_dr) & player_awake;
        st_s   = shot_dr & terrain_dr;
        sa_s   = alien_dr & {N_ALIEN{shot_dr}};
        fire_s = (|sa_s) | st_s;
        pg_s   = gold_dr & {N_GOLD{player_dr & player_awake}};
        push_s = {N_GOLD{1'b0}};
        eat_s  = {N_GOLD{1'b0}};
        kill_s = pa_s;
        for (int i = 0; i < N_GOLD; i++) begin
            push_s[i] = pg_s[i] & (gold_state[i] == GOLD_STILL);
            eat_s[i]  = pg_s[i] & (gold_state[i] == GOLD_BROKEN);
            kill_s    = kill_s | (pg_s[i] & (gold_state[i] == GOLD_FALLING));
        end
    end

    // Death sequencing; every transition happens on a frame boundary.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ALIVE: begin
                if (startOfFrame && kill_lat_r) state_next_s = DYING;
                else                            state_next_s = ALIVE;
            end
            DYING: begin
                if (startOfFrame && (frame_cnt_r == LAST_FRAME)) state_next_s = RESPAWN;
                else                                             state_next_s = DYING;
            end
            RESPAWN: begin
                if (startOfFrame) state_next_s = ALIVE;
                else              state_next_s = RESPAWN;
            end
            default: state_next_s = ALIVE;
        endcase
    end

    // State decodes used to gate publication.
    always_comb begin
        alive_s      = (state_r == ALIVE);
        respawn_s    = (state_r == RESPAWN);
        stay_alive_s = (state_next_s == ALIVE);
    end

    // State, dying-frame counter, kill latch and death outputs.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_r      <= ALIVE;
            frame_cnt_r  <= {CW{1'b0}};
            kill_lat_r   <= 1'b0;
            player_died  <= 1'b0;
            player_dying <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            player_died  <= startOfFrame & alive_s & kill_lat_r;
            player_dying <= (state_next_s == DYING);
            if (startOfFrame) begin
                kill_lat_r <= kill_s;
            end else if (respawn_s) begin
                kill_lat_r <= 1'b0;
            end else begin
                kill_lat_r <= kill_lat_r | kill_s;
            end
            if (state_r != DYING) begin
                frame_cnt_r <= {CW{1'b0}};
            end else if (startOfFrame && (frame_cnt_r != CNT_MAX)) begin
                frame_cnt_r <= frame_cnt_r + CNT_ONE;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // The terrain level must never be seen while the player is dying, so it looks at the next state.
    frame_event_latch #(.W(1), .PRIO_W(0), .LEVEL(1'b1)) u_terrain (
        .clk   (clk),
        .reset (resetN),
        .sof   (startOfFrame),
        .hold  (respawn_s),
        .set   (pt_s),
        .en    (stay_alive_s),
        .pulse (collision_player_terrain)
    );

    frame_event_latch #(.W(N_ALIEN + 1), .PRIO_W(N_ALIEN), .LEVEL(1'b0)) u_shot (
        .clk   (clk),
        .reset (resetN),
        .sof   (startOfFrame),
        .hold  (respawn_s),
        .set   ({fire_s, sa_s}),
        .en    ({(N_ALIEN + 1){~respawn_s}}),
        .pulse (shot_pulse_s)
    );

    frame_event_latch #(.W(2 * N_GOLD), .PRIO_W(0), .LEVEL(1'b0)) u_gold (
        .clk   (clk),
        .reset (resetN),
        .sof   (startOfFrame),
        .hold  (respawn_s),
        .set   ({eat_s, push_s}),
        .en    ({(2 * N_GOLD){alive_s}}),
        .pulse (gold_pulse_s)
    );

    assign {colision_fire, alien_died}       = shot_pulse_s;
    assign {player_eat_gold, collision_gold} = gold_pulse_s;

`ifdef GAME_EVENT_STATS_EN
    // Saturating totals of published kills and collected gold.
    always_ff @(posedge clk) begin
        if (resetN) begin
            aliens_killed <= 8'd0;
            gold_eaten    <= 8'd0;
        end else begin
            aliens_killed <= sat_add8(aliens_killed, popcount8(8'(alien_died)));
            gold_eaten    <= sat_add8(gold_eaten, popcount8(8'(player_eat_gold)));
        end
    end
`endif

endmodule

// File: tb/tb_game_event_controller.sv
// Directed plus randomized bench for game_event_controller against a frame-level reference model.
// Define GAME_EVENT_STATS_EN to include the statistics outputs and their saturation test.
module tb_game_event_controller;
    import game_pkg::*;

    localparam int NG = 4;
    localparam int NA = 4;
    localparam int DF = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 resetN, startOfFrame, player_awake, player_dr, terrain_dr, shot_dr;
    logic [NA-1:0]        alien_dr;
    logic [NG-1:0]        gold_dr;
    gold_state_t [NG-1:0] gold_state;
    logic                 collision_player_terrain, colision_fire, player_died, player_dying;
    logic [NG-1:0]        collision_gold, player_eat_gold;
    logic [NA-1:0]        alien_died;
`ifdef GAME_EVENT_STATS_EN
    logic [7:0]           aliens_killed, gold_eaten;
`endif

    game_event_controller #(.N_GOLD(NG), .N_ALIEN(NA), .DEATH_FRAMES(DF)) dut (
        .clk                      (clk),
        .resetN                   (resetN),
        .startOfFrame             (startOfFrame),
        .player_awake             (player_awake),
        .player_dr                (player_dr),
        .terrain_dr               (terrain_dr),
        .shot_dr                  (shot_dr),
        .alien_dr                 (alien_dr),
        .gold_dr                  (gold_dr),
        .gold_state               (gold_state),
        .collision_player_terrain (collision_player_terrain),
        .colision_fire            (colision_fire),
        .collision_gold           (collision_gold),
        .player_eat_gold          (player_eat_gold),
        .alien_died               (alien_died),
`ifdef GAME_EVENT_STATS_EN
        .aliens_killed            (aliens_killed),
        .gold_eaten               (gold_eaten),
`endif
        .player_died              (player_died),
        .player_dying             (player_dying)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-frame sets of observed overlaps and the player's life phase.
    bit m_pt, m_st, m_kill, m_respawn;
    int m_sa, m_push, m_eat, m_dying_left;
    bit e_cpt, e_fire, e_died, e_dying;
    int e_alien, e_push, e_eat, e_ak, e_ge;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_step();
        bit pt, st, kill, alive;
        int sa, push, eat, old_alien, old_eat;
        pt   = player_dr && terrain_dr && player_awake;
        st   = shot_dr && terrain_dr;
        sa   = shot_dr ? int'(alien_dr) : 0;
        kill = player_dr && player_awake && (alien_dr != '0);
        push = 0;
        eat  = 0;
        for (int g = 0; g < NG; g++) begin
            if (player_dr && player_awake && gold_dr[g]) begin
                if (gold_state[g] == GOLD_STILL)        push |= (1 << g);
                else if (gold_state[g] == GOLD_BROKEN)  eat  |= (1 << g);
                else if (gold_state[g] == GOLD_FALLING) kill = 1'b1;
            end
        end
        old_alien = e_alien;
        old_eat   = e_eat;
        if (resetN) begin
            m_pt = 0; m_st = 0; m_kill = 0; m_respawn = 0;
            m_sa = 0; m_push = 0; m_eat = 0; m_dying_left = 0;
            e_cpt = 0; e_fire = 0; e_died = 0; e_dying = 0;
            e_alien = 0; e_push = 0; e_eat = 0; e_ak = 0; e_ge = 0;
        end else begin
            e_ak = sat255(e_ak + $countones(old_alien));
            e_ge = sat255(e_ge + $countones(old_eat));
            if (startOfFrame) begin
                alive   = (m_dying_left == 0) && !m_respawn;
                e_fire  = (m_sa != 0) || m_st;
                e_alien = m_sa & (-m_sa);
                e_push  = alive ? m_push : 0;
                e_eat   = alive ? m_eat : 0;
                e_died  = alive && m_kill;
                if (alive && m_kill) begin
                    m_dying_left = DF;
                end else if (m_dying_left > 0) begin
                    m_dying_left--;
                    if (m_dying_left == 0) m_respawn = 1;
                end else if (m_respawn) begin
                    m_respawn = 0;
                end
                e_dying = (m_dying_left > 0);
                e_cpt   = m_pt && (m_dying_left == 0) && !m_respawn;
                if (m_respawn) begin
                    m_pt = 0; m_st = 0; m_kill = 0; m_sa = 0; m_push = 0; m_eat = 0;
                end else begin
                    m_pt = pt; m_st = st; m_kill = kill; m_sa = sa; m_push = push; m_eat = eat;
                end
            end else begin
                e_fire = 0; e_alien = 0; e_push = 0; e_eat = 0; e_died = 0;
                if (!m_respawn) begin
                    m_pt |= pt; m_st |= st; m_kill |= kill;
                    m_sa |= sa; m_push |= push; m_eat |= eat;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("cpt",   32'(collision_player_terrain), 32'(e_cpt));
        check_eq("fire",  32'(colision_fire), 32'(e_fire));
        check_eq("alien", 32'(alien_died), e_alien);
        check_eq("push",  32'(collision_gold), e_push);
        check_eq("eat",   32'(player_eat_gold), e_eat);
        check_eq("died",  32'(player_died), 32'(e_died));
        check_eq("dying", 32'(player_dying), 32'(e_dying));
`ifdef GAME_EVENT_STATS_EN
        check_eq("akill", 32'(aliens_killed), e_ak);
        check_eq("geat",  32'(gold_eaten), e_ge);
`endif
    endtask

    task automatic clear_inputs();
        startOfFrame = 1'b0; player_awake = 1'b1; player_dr = 1'b0;
        terrain_dr = 1'b0; shot_dr = 1'b0; alien_dr = '0; gold_dr = '0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sof_tick();
        clear_inputs();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetN = 1'b1;
        tick();
        tick();
        resetN = 1'b0;
    endtask

    initial begin
        int frames;
        clear_inputs();
        gold_state = {NG{GOLD_WOBBLE}};
        resetN = 1'b1;
        do_reset();
        check_eq("rst_cpt", 32'(collision_player_terrain), 32'd0);
        check_eq("rst_dying", 32'(player_dying), 32'd0);

        // Player over terrain for 3 clk mid-frame.
        idle(3);
        player_dr = 1'b1; terrain_dr = 1'b1;
        tick(); tick(); tick();
        idle(2);
        sof_tick();
        check_eq("t1_cpt", 32'(collision_player_terrain), 32'd1);
        idle(5);
        check_eq("t1_hold", 32'(collision_player_terrain), 32'd1);
        sof_tick();
        check_eq("t1_clear", 32'(collision_player_terrain), 32'd0);

        // Two aliens hit in one frame: only the lowest index dies.
        idle(2);
        shot_dr = 1'b1; alien_dr = 4'b1010;
        tick();
        idle(2);
        sof_tick();
        check_eq("t2_alien", 32'(alien_died), 32'b0010);
        check_eq("t2_fire", 32'(colision_fire), 32'd1);
        tick();
        check_eq("t2_alien_once", 32'(alien_died), 32'd0);

        // Eat broken gold[2] and push still gold[0].
        gold_state[0] = GOLD_STILL; gold_state[2] = GOLD_BROKEN;
        player_dr = 1'b1; gold_dr = 4'b0101;
        tick();
        idle(2);
        sof_tick();
        check_eq("t3_eat", 32'(player_eat_gold), 32'b0100);
        check_eq("t3_push", 32'(collision_gold), 32'b0001);
        tick();
        check_eq("t3_once", 32'(player_eat_gold), 32'd0);

        // Falling gold kills; dying lasts DF frames with eats suppressed, then one respawn frame.
        gold_state[1] = GOLD_FALLING;
        player_dr = 1'b1; gold_dr = 4'b0010;
        tick();
        idle(3);
        sof_tick();
        check_eq("t4_died", 32'(player_died), 32'd1);
        check_eq("t4_dying", 32'(player_dying), 32'd1);
        tick();
        check_eq("t4_died_once", 32'(player_died), 32'd0);
        frames = 0;
        for (int f = 0; f < DF + 4; f++) begin
            if (!player_dying) break;
            frames++;
            player_dr = 1'b1; gold_dr = 4'b0100;
            tick();
            idle(3);
            sof_tick();
            check_eq("t4_no_eat", 32'(player_eat_gold), 32'd0);
        end
        check_eq("t4_frames", 32'(frames), 32'(DF));
        player_dr = 1'b1; gold_dr = 4'b0100;
        tick();
        idle(3);
        sof_tick();
        check_eq("t4_respawn", 32'(player_eat_gold), 32'd0);
        player_dr = 1'b1; gold_dr = 4'b0100;
        tick();
        idle(3);
        sof_tick();
        check_eq("t4_alive_eat", 32'(player_eat_gold), 32'b0100);

        // Overlap on the startOfFrame cycle belongs to the new frame.
        idle(2);
        sof_tick();
        player_dr = 1'b1; terrain_dr = 1'b1; startOfFrame = 1'b1;
        tick();
        check_eq("t5_not_now", 32'(collision_player_terrain), 32'd0);
        idle(3);
        sof_tick();
        check_eq("t5_next", 32'(collision_player_terrain), 32'd1);

        // Reset mid-frame discards pending overlaps.
        player_dr = 1'b1; terrain_dr = 1'b1; shot_dr = 1'b1; alien_dr = 4'b0001;
        tick(); tick();
        resetN = 1'b1;
        tick();
        resetN = 1'b0;
        idle(3);
        sof_tick();
        check_eq("rst_mid_cpt", 32'(collision_player_terrain), 32'd0);
        check_eq("rst_mid_fire", 32'(colision_fire), 32'd0);

        // Randomized frames, including occasional resets.
        for (int f = 0; f < 150; f++) begin
            int len;
            len = $urandom_range(2, 14);
            for (int g = 0; g < NG; g++) gold_state[g] = gold_state_t'(4'($urandom_range(0, 5)));
            for (int c = 0; c < len; c++) begin
                resetN       = ($urandom_range(0, 299) == 0);
                player_awake = ($urandom_range(0, 5) != 0);
                player_dr    = ($urandom_range(0, 2) == 0);
                terrain_dr   = ($urandom_range(0, 2) == 0);
                shot_dr      = ($urandom_range(0, 2) == 0);
                alien_dr     = ($urandom_range(0, 5) == 0) ? NA'($urandom) : '0;
                gold_dr      = ($urandom_range(0, 2) == 0) ? NG'($urandom) : '0;
                startOfFrame = (c == 0);
                tick();
            end
        end
        resetN = 1'b0;

`ifdef GAME_EVENT_STATS_EN
        // 300 eat events saturate the gold counter.
        do_reset();
        gold_state = {NG{GOLD_BROKEN}};
        for (int f = 0; f < 75; f++) begin
            player_dr = 1'b1; gold_dr = 4'hF;
            tick();
            idle(1);
            sof_tick();
        end
        idle(2);
        check_eq("t6_sat", 32'(gold_eaten), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
